timer_bank: RTL and testbench
=============================

// Module: timer_bank
// PURPOSE
//  Bank of NCH independent programmable delay timers sharing one free-running tick prescaler.
//  Each channel has a runtime-loadable period (in ticks), one-shot or periodic mode, and start/stop control.
//  Each channel emits a one-clock done pulse at expiry.
//  Used for display refresh/row timing and any other interval the controller needs, without one fixed-delay instance per interval.
// PARAMETERS
//  NCH            4     number of timer channels (>=1)
//  WIDTH          16    period/counter width in bits
//  CLKPD_NS       10    clk period in ns (100 MHz)
//  TICK_NS        1000  tick period in ns; must be a multiple of CLKPD_NS
//  DEFAULT_PERIOD 1000  reset value of every channel period (1..2**WIDTH-1)
//  DIV (derived)        TICK_NS/CLKPD_NS, clocks per tick (>=1)
// PORTS
//  clk       in   1                   system clock
//  rst_n     in   1                   asynchronous, active-low reset
//  start     in   NCH                 per-channel start/restart request (level sampled each clk)
//  stop      in   NCH                 per-channel stop request
//  periodic  in   NCH                 per-channel mode, sampled at start: 1=periodic, 0=one-shot
//  ld_valid  in   1                   period load strobe
//  ld_ch     in   max(1,$clog2(NCH))  channel index for load
//  ld_period in   WIDTH               new period in ticks
//  ld_err    out  1                   1-clk pulse: load rejected
//  tick      out  1                   1-clk prescaler tick, debug/observation
//  busy      out  NCH                 channel running
//  done      out  NCH                 1-clk expiry pulse per channel
// BEHAVIOUR
//  Reset (async assert, sync deassert use)
//   - prescaler=0; all counters=0; busy=0; done=0; ld_err=0.
//   - shadow and active periods = DEFAULT_PERIOD; mode regs=0.
//  Prescaler
//   - q counts 0..DIV-1 and wraps, free-running.
//   - tick=1 in the cycle q==DIV-1; DIV=1 gives tick every clk.
//   - Shared by all channels; first tick after start may come 1..DIV clocks later.
//  Period load
//   - On ld_valid, writes the shadow period of ld_ch.
//   - Rejected (shadow unchanged, ld_err=1 next cycle) if ld_period==0 or ld_ch>=NCH.
//   - The active period is copied from the shadow at start and at every periodic wrap.
//   - A load while running never changes the current interval.
//  Per-channel FSM: IDLE, RUN
//   - IDLE & start & !stop: cnt<=0, active<=shadow, mode<=periodic, busy<=1 -> RUN.
//   - RUN & start & !stop: restart, same actions; no done for the aborted interval.
//   - RUN & stop: busy<=0, cnt<=0 -> IDLE. stop wins over start and over a coincident expiry (no done).
//   - RUN & tick & cnt!=active-1: cnt<=cnt+1.
//   - RUN & tick & cnt==active-1, no stop/start: done<=1 next cycle, cnt<=0.
//     . periodic: active<=shadow, stay RUN.
//     . one-shot: busy<=0 at the same edge -> IDLE.
//   - IDLE & stop: no effect.
//  done/busy are registered. Expiry occurs exactly `active` ticks after busy rises.
//  With DIV=1, done rises exactly P clocks after busy rises.
//  Channels are fully independent. Simultaneous events on different channels all act in the same cycle.
//  rst_n low mid-run: immediate clear; no done is produced.
//  Counter width WIDTH; the maximum period 2**WIDTH-1 must not overflow.
// TESTING (bench instance NCH=3, WIDTH=8, TICK_NS=CLKPD_NS i.e. DIV=1 unless noted)
//  1 ch0 ld 5, one-shot start 1 clk -> busy 1; done single pulse 5 clks after busy rise; busy low with done.
//  2 ch1 ld 3, periodic start -> done every 3 clks, 4 pulses; stop in expiry cycle -> no 5th done, busy 0.
//  3 ch2 periodic P=4 running, ld 2 mid-interval -> current interval 4 clks, following intervals 2.
//  4 start+stop same cycle -> stays IDLE; ld_period=0 and ld_ch=3 -> ld_err pulse each, shadow unchanged.
//  5 DIV=100 instance, P=10 -> tick every 100 clks; done 901..1000 clks after start, aligned to tick.
//  6 rst_n low mid-run on all channels -> busy/done/cnt 0 immediately, periods back to DEFAULT_PERIOD.

Source files
------------

// File: rtl/timer_bank.sv
// Purpose : bank of NCH programmable delay timers sharing one free-running tick prescaler.
// Latency : done rises exactly `active` ticks after busy rises; ld_err one clk after ld_valid.
// Backpr. : none; loads are always accepted or rejected in one cycle, start/stop are level-sampled.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start/stop/periodic   per-channel control (NCH bits), periodic is sampled at start
//   ld_valid/ld_ch/ld_period  shadow period write; ld_err pulses when rejected
//   tick                  prescaler tick (one clk every DIV clks)
//   busy/done             per-channel running flag and one-clk expiry pulse
module timer_bank #(
  parameter int NCH            = 4,
  parameter int WIDTH          = 16,
  parameter int CLKPD_NS       = 10,
  parameter int TICK_NS        = 1000,
  parameter int DEFAULT_PERIOD = 1000,
  localparam int CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   start,
  input  logic [NCH-1:0]   stop,
  input  logic [NCH-1:0]   periodic,
  input  logic             ld_valid,
  input  logic [CHW-1:0]   ld_ch,
  input  logic [WIDTH-1:0] ld_period,
  output logic             ld_err,
  output logic             tick,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   done
);

  localparam int DIV = TICK_NS / CLKPD_NS;
  localparam int QW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // ---------------------------------------------------------------
  // Prescaler: q counts 0..DIV-1; with DIV=1 q stays 0 and tick is
  // permanently high.
  // ---------------------------------------------------------------
  logic [QW-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (q == QW'(DIV - 1)) begin
      q <= '0;
    end else begin
      q <= q + QW'(1);
    end
  end

  assign tick = (q == QW'(DIV - 1));

  // ---------------------------------------------------------------
  // Period load check. The extra bit on the compare keeps NCH that is
  // an exact power of two from wrapping to zero.
  // ---------------------------------------------------------------
  logic ld_ok;

  assign ld_ok = ld_valid && (ld_period != '0) &&
                 ({1'b0, ld_ch} < (CHW + 1)'(NCH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_err <= 1'b0;
    end else begin
      ld_err <= ld_valid && !ld_ok;
    end
  end

  // ---------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [0:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;
    logic             mode;
    logic             done_r;
    logic             sel_ld;
    logic             go;
    logic             last;

    assign sel_ld = ld_ok && (ld_ch == CHW'(i));
    assign go     = start[i] && !stop[i];
    // active is never zero (reset default and loads are both nonzero),
    // so active-1 cannot underflow; cnt never exceeds active-1.
    assign last   = (cnt == active - WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        shadow <= DEF_P;
        active <= DEF_P;
        mode   <= 1'b0;
        done_r <= 1'b0;
      end else begin
        done_r <= 1'b0;
        if (sel_ld) begin
          shadow <= ld_period;
        end
        case (state)
          ST_IDLE: begin
            if (go) begin
              cnt    <= '0;
              active <= shadow;
              mode   <= periodic[i];
              state  <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (stop[i]) begin
              // stop beats start and a coincident expiry
              cnt   <= '0;
              state <= ST_IDLE;
            end else if (start[i]) begin
              // restart: aborted interval produces no done
              cnt    <= '0;
              active <= shadow;
              mode   <= periodic[i];
            end else if (tick) begin
              if (last) begin
                done_r <= 1'b1;
                cnt    <= '0;
                if (mode) begin
                  active <= shadow;
                end else begin
                  state <= ST_IDLE;
                end
              end else begin
                cnt <= cnt + WIDTH'(1);
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign busy[i] = (state == ST_RUN);
    assign done[i] = done_r;
  end

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

  logic       clk;
  logic       rst_n;

  // main instance: NCH=3, WIDTH=8, DIV=1, DEFAULT_PERIOD=6
  logic [2:0] start, stop, periodic;
  logic       ld_valid;
  logic [1:0] ld_ch;
  logic [7:0] ld_period;
  logic       ld_err, tick;
  logic [2:0] busy, done;

  // prescaled instance: NCH=1, WIDTH=8, DIV=100, DEFAULT_PERIOD=10
  logic [0:0] start2, stop2, periodic2;
  logic       ld_valid2;
  logic [0:0] ld_ch2;
  logic [7:0] ld_period2;
  logic       ld_err2, tick2;
  logic [0:0] busy2, done2;

  int tests = 0;
  int fails = 0;

  timer_bank #(
    .NCH(3), .WIDTH(8), .CLKPD_NS(10), .TICK_NS(10), .DEFAULT_PERIOD(6)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .stop(stop), .periodic(periodic),
    .ld_valid(ld_valid), .ld_ch(ld_ch), .ld_period(ld_period),
    .ld_err(ld_err), .tick(tick), .busy(busy), .done(done)
  );

  timer_bank #(
    .NCH(1), .WIDTH(8), .CLKPD_NS(10), .TICK_NS(1000), .DEFAULT_PERIOD(10)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .start(start2), .stop(stop2), .periodic(periodic2),
    .ld_valid(ld_valid2), .ld_ch(ld_ch2), .ld_period(ld_period2),
    .ld_err(ld_err2), .tick(tick2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps until done[ch] is seen; n = clocks waited, -1 on timeout.
  task automatic wait_done(input int ch, input int maxc, output int n);
    n = 0;
    for (int k = 0; k < maxc; k++) begin
      step();
      n++;
      if (done[ch]) return;
    end
    n = -1;
  endtask

  task automatic load(input int ch, input int p);
    ld_valid  = 1'b1;
    ld_ch     = 2'(ch);
    ld_period = 8'(p);
    step();
    ld_valid  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n, m, acc, ptick, ph;

    rst_n = 1'b0;
    start = '0; stop = '0; periodic = '0;
    ld_valid = 1'b0; ld_ch = '0; ld_period = '0;
    start2 = '0; stop2 = '0; periodic2 = '0;
    ld_valid2 = 1'b0; ld_ch2 = '0; ld_period2 = '0;
    repeat (2) step();

    // reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ld_err", int'(ld_err), 0);
    chk("rst_tick_div1", int'(tick), 1);
    chk("rst_tick_div100", int'(tick2), 0);
    chk("rst_busy2", int'(busy2), 0);
    rst_n = 1'b1;
    step();

    // 1: ch0 one-shot P=5
    load(0, 5);
    chk("t1_ld_ok", int'(ld_err), 0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("t1_busy_rise", int'(busy[0]), 1);
    wait_done(0, 20, n);
    chk("t1_latency", n, 5);
    chk("t1_busy_fall", int'(busy[0]), 0);
    step();
    chk("t1_single_pulse", int'(done[0]), 0);

    // 2: ch1 periodic P=3, stop in the 5th expiry cycle
    load(1, 3);
    start[1] = 1'b1; periodic[1] = 1'b1;
    step();
    start[1] = 1'b0; periodic[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_done(1, 10, n);
      chk("t2_period", n, 3);
      chk("t2_busy", int'(busy[1]), 1);
    end
    step();
    step();
    stop[1] = 1'b1;
    step();
    stop[1] = 1'b0;
    chk("t2_stop_no_done", int'(done[1]), 0);
    chk("t2_stop_busy", int'(busy[1]), 0);
    acc = 0;
    repeat (4) begin step(); acc |= int'(done[1]); end
    chk("t2_quiet_after_stop", acc, 0);

    // 3: ch2 periodic P=4, reload 2 mid-interval
    load(2, 4);
    start[2] = 1'b1; periodic[2] = 1'b1;
    step();
    start[2] = 1'b0; periodic[2] = 1'b0;
    step();
    step();
    load(2, 2);
    wait_done(2, 10, m);
    chk("t3_current_interval", 3 + m, 4);
    wait_done(2, 10, n);
    chk("t3_next_interval_a", n, 2);
    wait_done(2, 10, n);
    chk("t3_next_interval_b", n, 2);
    stop[2] = 1'b1;
    step();
    stop[2] = 1'b0;
    chk("t3_stopped", int'(busy[2]), 0);

    // 4: start+stop together, rejected loads
    start[0] = 1'b1; stop[0] = 1'b1;
    step();
    start[0] = 1'b0; stop[0] = 1'b0;
    chk("t4_startstop_idle", int'(busy[0]), 0);
    acc = 0;
    repeat (7) begin step(); acc |= int'(done[0]); end
    chk("t4_startstop_no_done", acc, 0);
    load(0, 0);
    chk("t4_zero_err", int'(ld_err), 1);
    step();
    chk("t4_zero_err_pulse", int'(ld_err), 0);
    load(3, 7);
    chk("t4_badch_err", int'(ld_err), 1);
    step();
    chk("t4_badch_err_pulse", int'(ld_err), 0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    wait_done(0, 20, n);
    chk("t4_shadow_kept", n, 5);

    // 5: DIV=100 instance, P=10
    n = -1;
    for (int k = 0; k < 200; k++) begin
      step();
      if (tick2) begin n = 0; break; end
    end
    chk("t5_tick_seen", int'(n == 0), 1);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (tick2) begin n = k; break; end
    end
    chk("t5_tick_spacing", n, 100);
    ph = $urandom_range(0, 99);
    repeat (ph) step();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("t5_busy_rise", int'(busy2), 1);
    n = -1;
    ptick = 0;
    for (int k = 1; k <= 1100; k++) begin
      ptick = int'(tick2);
      step();
      if (done2[0]) begin n = k; break; end
    end
    chk("t5_latency_in_range", int'(n >= 901 && n <= 1000), 1);
    chk("t5_tick_aligned", ptick, 1);
    chk("t5_oneshot_idle", int'(busy2), 0);

    // 6: async reset mid-run on all channels
    start = 3'b111; periodic = 3'b110;
    step();
    start = '0; periodic = '0;
    step();
    step();
    chk("t6_pre_done2", int'(done[2]), 1);
    chk("t6_pre_busy", int'(busy), 7);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_done", int'(done), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_idle_after_rst", int'(busy), 0);
    start = 3'b011; periodic = 3'b010;
    step();
    start = '0; periodic = '0;
    wait_done(0, 20, n);
    chk("t6_default_period_ch0", n, 6);
    chk("t6_simul_done_ch1", int'(done[1]), 1);
    chk("t6_ch1_still_busy", int'(busy[1]), 1);
    chk("t6_ch0_oneshot_idle", int'(busy[0]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
